// File: rtl/freq_meter_param.sv
// Reciprocal-style frequency meter: gate on test edges, divide, convert to BCD, scan a 7-seg display.
// Optional FREQ_METER_HOLD_EN adds a hold input that freezes the published result.
module freq_meter_param #(
  parameter int CLK_STAND_FREQ = 100_000_000,
  parameter int GATE_CYCLES    = 75_000_000,
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 65536,
  parameter int CNT_W          = 32
) (
  input  logic              clk_stand,
  input  logic              rst,
  input  logic              sig_test,
`ifdef FREQ_METER_HOLD_EN
  input  logic              hold,
`endif
  output logic [CNT_W-1:0]  freq,
  output logic              freq_valid,
  output logic              overflow,
  output logic [DIGITS-1:0] dig,
  output logic [6:0]        seg
);

  localparam int TO_W   = $clog2(2*GATE_CYCLES + 1);
  localparam int BW     = $clog2(CNT_W + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BCD_W  = 4*DIGITS;

  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(2*GATE_CYCLES - 1);
  localparam logic [BW-1:0]      BIT_LAST = BW'(CNT_W - 1);
  localparam logic [CNT_W-1:0]   N_MAX    = '1;
  localparam logic [CNT_W-1:0]   GATE_C   = CNT_W'(GATE_CYCLES);
  localparam logic [2*CNT_W-1:0] FREQ_C   = (2*CNT_W)'(CLK_STAND_FREQ);
  localparam logic [63:0]        DISP_MAX = 64'(10**DIGITS) - 64'd1;

  typedef enum logic [2:0] {IDLE, ARM, GATE, DIV, BCD} state_t;

  state_t state, state_nxt;

  logic s0, s1, s2, test_edge;
  logic [TO_W-1:0]    tcnt;
  logic [CNT_W-1:0]   n_std, n_test, n_std_inc, n_test_inc;
  logic [BW-1:0]      bcnt;
  logic [CNT_W-1:0]   rem, lo, quo, q, bin;
  logic               sat;
  logic [2*CNT_W-1:0] prod;
  logic [CNT_W:0]     rem_sh, dvs;
  logic               qbit;
  logic [CNT_W-1:0]   rem_nxt;
  logic [BCD_W-1:0]   bcd, bcd_adj, bcd_nxt, disp;
  logic               close, tmo, bcd_done, pub_en;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic [DIGITS-1:0]  blank;
  logic [3:0]         cur;

`ifdef FREQ_METER_HOLD_EN
  assign pub_en = ~hold;
`else
  assign pub_en = 1'b1;
`endif

  // Synchronizer is left out of reset so a reset never fabricates an edge.
  always_ff @(posedge clk_stand) begin
    s0        <= sig_test;
    s1        <= s0;
    s2        <= s1;
    test_edge <= s1 & ~s2;
  end

  assign n_std_inc  = n_std + CNT_W'(1);
  assign n_test_inc = n_test + CNT_W'(1);
  assign prod       = FREQ_C * {{CNT_W{1'b0}}, n_test_inc};

  always_ff @(posedge clk_stand) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    close     = 1'b0;
    tmo       = 1'b0;
    bcd_done  = 1'b0;
    case (state)
      IDLE: state_nxt = ARM;
      ARM: begin
        if (test_edge) state_nxt = GATE;
        else if (tcnt == TO_LAST) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      GATE: begin
        if (test_edge && n_std >= GATE_C) begin
          close     = 1'b1;
          state_nxt = DIV;
        end else if (tcnt == TO_LAST || n_std == N_MAX) begin
          tmo       = 1'b1;
          state_nxt = IDLE;
        end
      end
      DIV: if (bcnt == BIT_LAST) state_nxt = BCD;
      BCD: begin
        if (bcnt == BIT_LAST) begin
          bcd_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Restoring division step; remainder stays below the divisor unless saturated.
  always_comb begin
    rem_sh  = {rem, lo[CNT_W-1]};
    dvs     = {1'b0, n_std};
    qbit    = (rem_sh >= dvs);
    rem_nxt = qbit ? CNT_W'(rem_sh - dvs) : rem_sh[CNT_W-1:0];
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_nxt = {bcd_adj[BCD_W-2:0], bin[CNT_W-1]};
  end

  always_ff @(posedge clk_stand) begin
    if (rst) begin
      tcnt   <= '0;
      n_std  <= '0;
      n_test <= '0;
      bcnt   <= '0;
      rem    <= '0;
      lo     <= '0;
      quo    <= '0;
      q      <= '0;
      bin    <= '0;
      sat    <= 1'b0;
      bcd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tcnt   <= '0;
          n_std  <= '0;
          n_test <= '0;
          bcnt   <= '0;
        end
        ARM: begin
          tcnt   <= test_edge ? '0 : tcnt + TO_W'(1);
          n_std  <= '0;
          n_test <= '0;
        end
        GATE: begin
          tcnt  <= tcnt + TO_W'(1);
          n_std <= n_std_inc;
          if (test_edge) n_test <= n_test_inc;
          if (close) begin
            rem  <= prod[2*CNT_W-1:CNT_W];
            lo   <= prod[CNT_W-1:0];
            sat  <= (prod[2*CNT_W-1:CNT_W] >= n_std_inc);
            bcnt <= '0;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          lo  <= lo << 1;
          quo <= {quo[CNT_W-2:0], qbit};
          if (bcnt == BIT_LAST) begin
            q    <= sat ? N_MAX : {quo[CNT_W-2:0], qbit};
            bin  <= sat ? N_MAX : {quo[CNT_W-2:0], qbit};
            bcd  <= '0;
            bcnt <= '0;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        BCD: begin
          bin  <= bin << 1;
          bcd  <= bcd_nxt;
          bcnt <= bcnt + BW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_stand) begin
    if (rst) begin
      freq       <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
      disp       <= '0;
    end else begin
      freq_valid <= 1'b0;
      if (pub_en && tmo) begin
        freq       <= '0;
        overflow   <= 1'b0;
        disp       <= '0;
        freq_valid <= 1'b1;
      end else if (pub_en && bcd_done) begin
        freq       <= q;
        overflow   <= (64'(q) > DISP_MAX);
        disp       <= bcd_nxt;
        freq_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_stand) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  // A digit is blank when it and every more significant digit are zero.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (disp[4*i +: 4] != 4'd0) lead = 1'b0;
      blank[i] = lead;
    end
  end

  assign cur = disp[4*int'(idx) +: 4];
  assign dig = ~(DIGITS'(1) << idx);

  always_comb begin
    if (overflow)                seg = 7'h3F;
    else if (blank[int'(idx)])   seg = 7'h7F;
    else                         seg = enc(cur);
  end

endmodule

// File: tb/tb_freq_meter_param.sv
// Scoreboard bench: an 8-digit and a 4-digit meter share clock, reset and test signal.
module tb_freq_meter_param;

  typedef struct packed {
    logic [31:0]     f;
    logic            ovf;
    logic [7:0][6:0] segs;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, sig = 1'b0;
`ifdef FREQ_METER_HOLD_EN
  logic hold = 1'b0;
`endif
  logic [31:0] f8, f4;
  logic        fv8, fv4, ov8, ov4;
  logic [7:0]  dig8;
  logic [3:0]  dig4;
  logic [6:0]  seg8, seg4;

  exp_t q8[$], q4[$];
  int checks = 0, errors = 0, seen8 = 0, seen4 = 0, tgt = 0, per = 0, ph = 0;

  always #5 clk = ~clk;

  freq_meter_param #(.CLK_STAND_FREQ(100_000_000), .GATE_CYCLES(1000), .DIGITS(8),
                     .SCAN_DIV(4), .CNT_W(32)) u8 (
    .clk_stand(clk), .rst(rst), .sig_test(sig),
`ifdef FREQ_METER_HOLD_EN
    .hold(hold),
`endif
    .freq(f8), .freq_valid(fv8), .overflow(ov8), .dig(dig8), .seg(seg8));

  freq_meter_param #(.CLK_STAND_FREQ(100_000_000), .GATE_CYCLES(1000), .DIGITS(4),
                     .SCAN_DIV(4), .CNT_W(32)) u4 (
    .clk_stand(clk), .rst(rst), .sig_test(sig),
`ifdef FREQ_METER_HOLD_EN
    .hold(hold),
`endif
    .freq(f4), .freq_valid(fv4), .overflow(ov4), .dig(dig4), .seg(seg4));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int low_idx(input logic [7:0] d, input int n);
    int k;
    k = 0;
    for (int i = 0; i < n; i++) if (!d[i]) k = i;
    return k;
  endfunction

  // Periodic test signal, one rising edge every per clocks.
  initial forever begin
    @(negedge clk);
    if (per == 0) begin
      ph  = 0;
      sig = 1'b0;
    end else begin
      ph  = (ph + 1 >= per) ? 0 : ph + 1;
      sig = (ph < (per + 1) / 2);
    end
  end

  initial forever begin
    @(negedge clk);
    if (fv8) begin
      exp_t e;
      if (q8.size() == 0) begin
        chk("u8 unexpected freq_valid", 64'(f8), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q8.pop_front();
        chk("u8 freq", 64'(f8), 64'(e.f));
        chk("u8 overflow", 64'(ov8), 64'(e.ovf));
        @(negedge clk);
        chk("u8 freq_valid one cycle", 64'(fv8), 64'd0);
        for (int c = 0; c < 32; c++) begin
          int k;
          k = low_idx(dig8, 8);
          chk("u8 dig one-hot", 64'($countones(~dig8)), 64'd1);
          chk("u8 seg", 64'(seg8), 64'(e.segs[k]));
          @(negedge clk);
        end
        seen8++;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (fv4) begin
      exp_t e;
      if (q4.size() == 0) begin
        chk("u4 unexpected freq_valid", 64'(f4), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q4.pop_front();
        chk("u4 freq", 64'(f4), 64'(e.f));
        chk("u4 overflow", 64'(ov4), 64'(e.ovf));
        @(negedge clk);
        chk("u4 freq_valid one cycle", 64'(fv4), 64'd0);
        for (int c = 0; c < 16; c++) begin
          int k;
          k = low_idx({4'hF, dig4}, 4);
          chk("u4 dig one-hot", 64'($countones(~dig4)), 64'd1);
          chk("u4 seg", 64'(seg4), 64'(e.segs[k]));
          @(negedge clk);
        end
        seen4++;
      end
    end
  end

  task automatic start(input int p);
    @(negedge clk);
    rst = 1'b1;
    per = p;
    repeat (4) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input int n, input exp_t e8, input exp_t e4);
    for (int i = 0; i < n; i++) begin
      q8.push_back(e8);
      q4.push_back(e4);
    end
    tgt += n;
  endtask

  task automatic wait_seen();
    int c;
    c = 0;
    while (!(seen8 >= tgt && seen4 >= tgt) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk("results within budget", 64'(seen8 >= tgt && seen4 >= tgt), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam logic [6:0] B = 7'h7F, Z = 7'h40, D = 7'h3F;
  localparam exp_t E8_5M  = '{f: 32'd5_000_000,  ovf: 1'b0, segs: {B, 7'h12, Z, Z, Z, Z, Z, Z}};
  localparam exp_t E8_33M = '{f: 32'd33_333_333, ovf: 1'b0, segs: {8{7'h30}}};
  localparam exp_t E8_10M = '{f: 32'd10_000_000, ovf: 1'b0, segs: {7'h79, Z, Z, Z, Z, Z, Z, Z}};
  localparam exp_t E8_0   = '{f: 32'd0,          ovf: 1'b0, segs: {B, B, B, B, B, B, B, Z}};
  localparam exp_t E4_5M  = '{f: 32'd5_000_000,  ovf: 1'b1, segs: {28'd0, D, D, D, D}};
  localparam exp_t E4_33M = '{f: 32'd33_333_333, ovf: 1'b1, segs: {28'd0, D, D, D, D}};
  localparam exp_t E4_10M = '{f: 32'd10_000_000, ovf: 1'b1, segs: {28'd0, D, D, D, D}};
  localparam exp_t E4_0   = '{f: 32'd0,          ovf: 1'b0, segs: {28'd0, B, B, B, Z}};

  initial begin
    int c;
    repeat (3) @(negedge clk);
    chk("reset freq", 64'(f8), 64'd0);
    chk("reset freq_valid", 64'(fv8), 64'd0);
    chk("reset overflow", 64'(ov8), 64'd0);
    chk("reset dig8", 64'(dig8), 64'hFE);
    chk("reset seg8", 64'(seg8), 64'h40);
    chk("reset dig4", 64'(dig4), 64'hE);

    // period 20: 5 MHz, fits 8 digits, overflows 4 digits
    start(20);
    push(2, E8_5M, E4_5M);
    wait_seen();

    // period 3: 33,333,333 Hz
    start(3);
    push(2, E8_33M, E4_33M);
    wait_seen();

    // no test edges: timeout publishes zero after 2*GATE_CYCLES
    start(0);
    push(1, E8_0, E4_0);
    c = 0;
    while (!fv8 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("timeout latency in window", 64'(c >= 1995 && c <= 2010), 64'd1);
    wait_seen();

    // reset pulse in the middle of a gate
    start(20);
    push(1, E8_5M, E4_5M);
    wait_seen();
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midgate rst freq", 64'(f8), 64'd0);
    chk("midgate rst freq_valid", 64'(fv8), 64'd0);
    chk("midgate rst overflow4", 64'(ov4), 64'd0);
    chk("midgate rst dig8", 64'(dig8), 64'hFE);
    chk("midgate rst seg8", 64'(seg8), 64'h40);
    chk("midgate rst freq4", 64'(f4), 64'd0);
    push(1, E8_5M, E4_5M);
    wait_seen();

`ifdef FREQ_METER_HOLD_EN
    // hold freezes the published value while the period changes
    @(negedge clk);
    hold = 1'b1;
    per  = 10;
    repeat (3000) @(negedge clk);
    chk("hold freq8", 64'(f8), 64'd5_000_000);
    chk("hold freq4", 64'(f4), 64'd5_000_000);
    chk("hold overflow8", 64'(ov8), 64'd0);
    hold = 1'b0;
    push(1, E8_10M, E4_10M);
    wait_seen();
`endif

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
